cache_line_mem_responder: RTL and testbench
===========================================

// Module: cache_line_mem_responder
// PURPOSE
//  Backing-memory responder on the memory side of the set-associative cache's line interface.
//  Serves line fills: a block read request returns BLOCK_WORDS words as a burst.
//  Accepts dirty-line writebacks: a block write request is followed by BLOCK_WORDS data words.
//  Holds NUM_BLOCKS x BLOCK_WORDS words and self-clears to zero after reset.
// PARAMETERS
//  NUM_BLOCKS    256  lines in memory; must be a power of two
//  BLOCK_WORDS   16   words per line; must be a power of two
//  WORD_W        32   data word width in bits
//  BLOCK_ADDR_W  8    request block-address width; equals $clog2(NUM_BLOCKS)
//  READ_LATENCY  4    idle cycles between read acceptance and the first read beat (0 allowed)
// PORTS
//  clk        in   1             single clock; all logic on posedge
//  rst_n      in   1             synchronous active-low reset
//  req_valid  in   1             request present
//  req_ready  out  1             request accepted when req_valid && req_ready
//  req_write  in   1             1 = writeback, 0 = line fill
//  req_block  in   BLOCK_ADDR_W  line index in memory
//  wr_valid   in   1             writeback data beat present
//  wr_data    in   WORD_W        writeback word, beats sent in word order 0..BLOCK_WORDS-1
//  wr_ready   out  1             writeback beat taken when wr_valid && wr_ready
//  wr_done    out  1             one-cycle pulse after the last writeback beat is stored
//  rd_valid   out  1             fill beat present
//  rd_data    out  WORD_W        fill word, beats in word order 0..BLOCK_WORDS-1
//  rd_last    out  1             high with the final fill beat
//  rd_ready   in   1             fill beat consumed when rd_valid && rd_ready
//  busy       out  1             high in every state except IDLE
// BEHAVIOUR
//  States: INIT, IDLE, RD_WAIT, RD_BEAT, WR_BEAT.
//  Reset (rst_n == 0 at a clock edge):
//   - Next state is INIT; line counter and beat counter clear to 0.
//   - req_ready, wr_ready, wr_done, rd_valid and rd_last are 0. rd_data is 0. busy is 1.
//  INIT: clears one whole line per cycle at line index = line counter, for NUM_BLOCKS cycles.
//   After line NUM_BLOCKS-1 is cleared, the next state is IDLE. No request is accepted during INIT.
//  IDLE: req_ready = 1 (registered, so it is 1 in the cycle IDLE is entered). busy = 0.
//   On acceptance: latch req_block; clear the beat counter; req_ready drops in the next cycle.
//   - Read with READ_LATENCY > 0: go to RD_WAIT. With READ_LATENCY == 0: go to RD_BEAT.
//   - Write: go to WR_BEAT.
//  RD_WAIT: counts READ_LATENCY cycles, then goes to RD_BEAT.
//   Timing: acceptance at edge T gives first rd_valid in cycle T+1+READ_LATENCY.
//  RD_BEAT: rd_valid = 1, rd_data = mem[blk][beat], rd_last = (beat == BLOCK_WORDS-1).
//   - While rd_valid && !rd_ready, rd_data and rd_last are held stable.
//   - On a handshake the beat counter increments.
//   - The handshake on the last beat returns to IDLE; rd_valid is 0 in the next cycle.
//  WR_BEAT: wr_ready = 1. Each handshake writes mem[blk][beat] = wr_data and increments the beat counter.
//   - wr_valid gaps are allowed; no beat is dropped or duplicated.
//   - The handshake on the last beat returns to IDLE and pulses wr_done in that next cycle.
//  wr_valid while not in WR_BEAT is ignored (wr_ready = 0).
//  rd_ready while rd_valid = 0 has no effect.
//  req_valid held while busy stays pending. It is accepted on the first IDLE cycle, so back-to-back
//   transactions cost exactly 1 IDLE cycle between them.
//  Beat counter width is $clog2(BLOCK_WORDS). It wraps to 0 only when the state returns to IDLE.
//  Reset mid-transaction aborts the transaction at once and reruns INIT.
//   Any partial writeback is discarded, because INIT zeroes the whole memory.
//  Read-after-write of the same line (write completes, then read accepted) returns the new data.
//   There is no bypass path; ordering is guaranteed because only one transaction is active at a time.
// STRUCTURE
//  Package cache_mem_pkg:
//   - resp_state_e enum.
//   - Default constants for NUM_BLOCKS, BLOCK_WORDS, WORD_W, shared with the cache.
//   - Function line_addr(tag, set) = tag*NUM_SETS + set, matching the cache's writeback address rule.
//  Sub-module mem_line_store holds the storage array:
//   - One write-word port: addr, word index, data, enable.
//   - One whole-line clear port: addr, enable.
//   - Combinational read word select.
//  The top level holds the FSM, the latency/line/beat counters and all handshake registers.
// TESTING
//  1. Release reset -> req_ready = 0 for 256 cycles, then 1. Read block 5 -> 16 beats of 0,
//     rd_last only on beat 16, first rd_valid 5 cycles after acceptance.
//  2. Write block 0x22 with words 0x100+i (i = 0..15) -> wr_done pulses once.
//     Read block 0x22 -> returns 0x100..0x10F in order. Block 0x23 still reads as 0.
//  3. Read with rd_ready toggling 1,0,0,1,... -> rd_data stable while stalled, all 16 words
//     delivered exactly once, busy drops the cycle after the last handshake.
//  4. Write with random gaps in wr_valid, and a stray wr_valid while IDLE -> only the 16 in-burst words
//     are stored; the stray beat is ignored.
//  5. Write block 7, then assert rst_n = 0 during read beat 7 of block 7 -> rd_valid = 0 next cycle,
//     INIT reruns, and a later read of block 7 returns all zeros.
//  6. req_valid held continuously, alternating write then read of block 0xFF -> exactly one IDLE
//     cycle between transactions; the read returns the just-written data.

Source files
------------

// File: rtl/cache_mem_pkg.sv
// Shared definitions for the cache's backing-memory responder.
//  - resp_state_e : responder FSM states.
//  - DEF_*        : default geometry, shared with the cache.
//  - line_addr()  : memory line index for a (tag, set) pair. It matches the
//                   cache's writeback address rule.
package cache_mem_pkg;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        IDLE    = 3'd1,
        RD_WAIT = 3'd2,
        RD_BEAT = 3'd3,
        WR_BEAT = 3'd4
    } resp_state_e;

    localparam int DEF_NUM_BLOCKS   = 256;
    localparam int DEF_BLOCK_WORDS  = 16;
    localparam int DEF_WORD_W       = 32;
    localparam int DEF_BLOCK_ADDR_W = 8;

    // Cache geometry: 64 sets, remaining line-address bits are tag.
    localparam int NUM_SETS = 64;
    localparam int SET_W    = 6;
    localparam int TAG_W    = DEF_BLOCK_ADDR_W - SET_W;

    function automatic logic [DEF_BLOCK_ADDR_W-1:0] line_addr(
        input logic [TAG_W-1:0] tagIdx,
        input logic [SET_W-1:0] setIdx
    );
        return DEF_BLOCK_ADDR_W'(tagIdx) * DEF_BLOCK_ADDR_W'(NUM_SETS)
             + DEF_BLOCK_ADDR_W'(setIdx);
    endfunction

endpackage

// File: rtl/mem_line_store.sv
// Line-organised storage array: NUM_BLOCKS lines of BLOCK_WORDS words.
// Ports:
//  clk             clock; all writes happen on posedge
//  clrEn, clrAddr  zero a whole line in one cycle (takes priority over a write)
//  wrEn, wrAddr,
//  wrWord, wrData  write one word of one line
//  rdAddr, rdWord  combinational word select
//  rdData          selected word
module mem_line_store #(
    parameter int NUM_BLOCKS  = 256,
    parameter int BLOCK_WORDS = 16,
    parameter int WORD_W      = 32,
    parameter int ADDR_W      = 8,
    parameter int BEAT_W      = 4
) (
    input  logic              clk,
    input  logic              clrEn,
    input  logic [ADDR_W-1:0] clrAddr,
    input  logic              wrEn,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [BEAT_W-1:0] wrWord,
    input  logic [WORD_W-1:0] wrData,
    input  logic [ADDR_W-1:0] rdAddr,
    input  logic [BEAT_W-1:0] rdWord,
    output logic [WORD_W-1:0] rdData
);

    // Packed words within a line so a whole line can be cleared in one write.
    logic [BLOCK_WORDS-1:0][WORD_W-1:0] mem [NUM_BLOCKS];

    always_ff @(posedge clk) begin
        if (clrEn) begin
            mem[clrAddr] <= '0;
        end else if (wrEn) begin
            mem[wrAddr][wrWord] <= wrData;
        end
    end

    assign rdData = mem[rdAddr][rdWord];

endmodule

// File: rtl/cache_line_mem_responder.sv
// Backing-memory responder on the memory side of the cache line interface.
// Serves line fills (block read -> BLOCK_WORDS-beat burst) and accepts
// dirty-line writebacks (block write + BLOCK_WORDS data beats). After reset
// the whole memory is zeroed one line per cycle before requests are taken.
// Ports:
//  clk, rst_n                         clock, synchronous active-low reset
//  req_valid/req_ready/req_write/
//  req_block                          request channel
//  wr_valid/wr_data/wr_ready          writeback beat channel
//  wr_done                            1-cycle pulse after last writeback beat
//  rd_valid/rd_data/rd_last/rd_ready  fill beat channel
//  busy                               high in every state except IDLE
// Handshakes: a transfer happens on a posedge where valid && ready are both
// high; the source holds its payload stable until that edge.
module cache_line_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int NUM_BLOCKS   = DEF_NUM_BLOCKS,
    parameter int BLOCK_WORDS  = DEF_BLOCK_WORDS,
    parameter int WORD_W       = DEF_WORD_W,
    parameter int BLOCK_ADDR_W = DEF_BLOCK_ADDR_W,
    parameter int READ_LATENCY = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [BLOCK_ADDR_W-1:0] req_block,
    input  logic                    wr_valid,
    input  logic [WORD_W-1:0]       wr_data,
    output logic                    wr_ready,
    output logic                    wr_done,
    output logic                    rd_valid,
    output logic [WORD_W-1:0]       rd_data,
    output logic                    rd_last,
    input  logic                    rd_ready,
    output logic                    busy
);

    localparam int BEAT_W = $clog2(BLOCK_WORDS);
    localparam int LAT_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [BEAT_W-1:0]       LAST_BEAT = BEAT_W'(BLOCK_WORDS - 1);
    localparam logic [BLOCK_ADDR_W-1:0] LAST_LINE = BLOCK_ADDR_W'(NUM_BLOCKS - 1);
    localparam logic [LAT_W-1:0]        LAST_WAIT =
        LAT_W'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    resp_state_e             state, nextState;
    logic [BLOCK_ADDR_W-1:0] lineCnt;
    logic [BLOCK_ADDR_W-1:0] blkReg;
    logic [BEAT_W-1:0]       beatCnt;
    logic [LAT_W-1:0]        latCnt;
    logic                    wrDoneReg;

    logic                    reqReadyC, wrReadyC, rdValidC, busyC;
    logic                    clrEn, wrEn;
    logic [WORD_W-1:0]       storeData;

    // Next-state and state-decoded handshake outputs.
    always_comb begin
        nextState = state;
        reqReadyC = 1'b0;
        wrReadyC  = 1'b0;
        rdValidC  = 1'b0;
        busyC     = 1'b1;
        clrEn     = 1'b0;
        wrEn      = 1'b0;
        case (state)
            INIT: begin
                clrEn = 1'b1;
                if (lineCnt == LAST_LINE) nextState = IDLE;
            end
            IDLE: begin
                reqReadyC = 1'b1;
                busyC     = 1'b0;
                if (req_valid) begin
                    if (req_write)              nextState = WR_BEAT;
                    else if (READ_LATENCY > 0)  nextState = RD_WAIT;
                    else                        nextState = RD_BEAT;
                end
            end
            RD_WAIT: begin
                if (latCnt == LAST_WAIT) nextState = RD_BEAT;
            end
            RD_BEAT: begin
                rdValidC = 1'b1;
                if (rd_ready && beatCnt == LAST_BEAT) nextState = IDLE;
            end
            WR_BEAT: begin
                wrReadyC = 1'b1;
                // A beat in flight at a reset edge is dropped; INIT wipes it anyway.
                wrEn     = wr_valid && rst_n;
                if (wr_valid && beatCnt == LAST_BEAT) nextState = IDLE;
            end
            default: nextState = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= INIT;
            lineCnt   <= '0;
            beatCnt   <= '0;
            latCnt    <= '0;
            blkReg    <= '0;
            wrDoneReg <= 1'b0;
        end else begin
            state     <= nextState;
            wrDoneReg <= 1'b0;
            case (state)
                INIT: lineCnt <= lineCnt + 1'b1;
                IDLE: begin
                    if (req_valid) begin
                        blkReg  <= req_block;
                        beatCnt <= '0;
                        latCnt  <= '0;
                    end
                end
                RD_WAIT: latCnt <= latCnt + 1'b1;
                RD_BEAT: begin
                    if (rd_ready) beatCnt <= beatCnt + 1'b1;
                end
                WR_BEAT: begin
                    if (wr_valid) begin
                        beatCnt <= beatCnt + 1'b1;
                        if (beatCnt == LAST_BEAT) wrDoneReg <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    mem_line_store #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .BLOCK_WORDS(BLOCK_WORDS),
        .WORD_W     (WORD_W),
        .ADDR_W     (BLOCK_ADDR_W),
        .BEAT_W     (BEAT_W)
    ) uStore (
        .clk    (clk),
        .clrEn  (clrEn),
        .clrAddr(lineCnt),
        .wrEn   (wrEn),
        .wrAddr (blkReg),
        .wrWord (beatCnt),
        .wrData (wr_data),
        .rdAddr (blkReg),
        .rdWord (beatCnt),
        .rdData (storeData)
    );

    // blkReg and beatCnt only move on a handshake, so rd_data/rd_last hold
    // steady while the consumer stalls.
    assign req_ready = reqReadyC;
    assign wr_ready  = wrReadyC;
    assign wr_done   = wrDoneReg;
    assign rd_valid  = rdValidC;
    assign rd_data   = rdValidC ? storeData : '0;
    assign rd_last   = rdValidC && (beatCnt == LAST_BEAT);
    assign busy      = busyC;

endmodule

// File: tb/tb_cache_line_mem_responder.sv
module tb_cache_line_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [7:0]  req_block = '0;
  logic        wr_valid = 1'b0;
  logic [31:0] wr_data = '0;
  logic        wr_ready;
  logic        wr_done;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        rd_ready = 1'b0;
  logic        busy;

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  cache_line_mem_responder dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_block(req_block),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready), .wr_done(wr_done),
    .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last), .rd_ready(rd_ready),
    .busy(busy)
  );

  int errors = 0;
  int checks = 0;
  int acc_cyc = 0;
  logic [31:0] model [256][16];
  logic [31:0] exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_model();
    for (int b = 0; b < 256; b++)
      for (int w = 0; w < 16; w++)
        model[b][w] = '0;
  endtask

  // driver tasks (all start and end on a negedge)
  task automatic wait_idle();
    int n = 0;
    while (req_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_idle: req_ready=%b required 1 within 400 cycles", req_ready);
    end
  endtask

  task automatic issue_req(input logic wr, input logic [7:0] blk);
    wait_idle();
    req_valid = 1'b1;
    req_write = wr;
    req_block = blk;
    acc_cyc   = cyc;
    @(negedge clk);
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  task automatic write_burst(input logic [7:0] blk, input logic [31:0] base, input int gaps);
    int i = 0;
    int n = 0;
    bit early = 0;
    issue_req(1'b1, blk);
    while (i < 16 && n < 300) begin
      if (wr_done === 1'b1) early = 1;
      if (gaps != 0 && $urandom_range(0, 2) == 0) begin
        wr_valid = 1'b0;
        wr_data  = 32'hBAD0_0000 | 32'($urandom_range(0, 65535));
      end else begin
        wr_valid = 1'b1;
        wr_data  = base + 32'(i);
        if (wr_ready === 1'b1) i++;
      end
      @(negedge clk);
      n++;
    end
    wr_valid = 1'b0;
    checks++;
    if (i != 16) begin
      errors++;
      $display("FAIL write_beats blk=%0h: accepted %0d beats, required 16", blk, i);
    end
    checks++;
    if (wr_done !== 1'b1 || early) begin
      errors++;
      $display("FAIL wr_done_pulse blk=%0h: wr_done=%b early=%0d, required 1 only after last beat", blk, wr_done, early);
    end
    @(negedge clk);
    checks++;
    if (wr_done !== 1'b0) begin
      errors++;
      $display("FAIL wr_done_width blk=%0h: wr_done=%b, required 0", blk, wr_done);
    end
    for (int k = 0; k < 16; k++) model[blk][k] = base + 32'(k);
  endtask

  // scoreboard consumer: pops exp_q on each fill handshake
  task automatic collect_read(input int mode);
    int beat = 0;
    int n = 0;
    int k = 0;
    bit seen = 0;
    bit stalled = 0;
    logic [31:0] held = '0;
    logic held_last = 1'b0;
    logic [31:0] e;
    logic exp_last;
    while (beat < 16 && n < 300) begin
      if (rd_valid === 1'b1) begin
        if (!seen) begin
          seen = 1;
          checks++;
          if (cyc - acc_cyc != 5) begin
            errors++;
            $display("FAIL rd_latency: first rd_valid %0d cycles after accept, required 5", cyc - acc_cyc);
          end
        end
        if (stalled) begin
          checks++;
          if (rd_data !== held || rd_last !== held_last) begin
            errors++;
            $display("FAIL rd_stall_stable beat %0d: data=%h last=%b, required %h %b", beat, rd_data, rd_last, held, held_last);
          end
        end
        rd_ready = (mode == 0) ? 1'b1 : ((k % 3) == 0);
        k++;
        if (rd_ready) begin
          e = exp_q.pop_front();
          exp_last = (beat == 15);
          checks++;
          if (rd_data !== e) begin
            errors++;
            $display("FAIL rd_data beat %0d: got %h, required %h", beat, rd_data, e);
          end
          checks++;
          if (rd_last !== exp_last) begin
            errors++;
            $display("FAIL rd_last beat %0d: got %b, required %b", beat, rd_last, exp_last);
          end
          beat++;
          stalled = 0;
        end else begin
          stalled   = 1;
          held      = rd_data;
          held_last = rd_last;
        end
      end else begin
        rd_ready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      n++;
    end
    rd_ready = 1'b0;
    checks++;
    if (beat != 16) begin
      errors++;
      $display("FAIL rd_beats: received %0d beats, required 16", beat);
      exp_q.delete();
    end
    checks++;
    if (rd_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rd_end: rd_valid=%b busy=%b, required 0 0", rd_valid, busy);
    end
  endtask

  task automatic read_burst(input logic [7:0] blk, input int mode);
    for (int k = 0; k < 16; k++) exp_q.push_back(model[blk][k]);
    issue_req(1'b0, blk);
    collect_read(mode);
  endtask

  // tests
  task automatic test_reset();
    int n = 0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, wr_ready, wr_done, rd_valid, rd_last, busy} !== 6'b000001) begin
      errors++;
      $display("FAIL reset_ctrl: {req_ready,wr_ready,wr_done,rd_valid,rd_last,busy}=%b, required 000001",
               {req_ready, wr_ready, wr_done, rd_valid, rd_last, busy});
    end
    checks++;
    if (rd_data !== 32'h0) begin
      errors++;
      $display("FAIL reset_rd_data: got %h, required 0", rd_data);
    end
    rst_n = 1'b1;
    while (req_ready !== 1'b1 && n < 1000) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n != 256) begin
      errors++;
      $display("FAIL init_cycles: req_ready low for %0d cycles, required 256", n);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy: busy=%b, required 0", busy);
    end
    clear_model();
  endtask

  task automatic test_basic_read();
    read_burst(8'h05, 0);
  endtask

  task automatic test_write_read();
    write_burst(8'h22, 32'h100, 0);
    read_burst(8'h22, 0);
    read_burst(8'h23, 0);
  endtask

  task automatic test_stall_read();
    read_burst(8'h22, 1);
  endtask

  task automatic test_gap_write();
    bit bad = 0;
    logic [31:0] base;
    base = $urandom & 32'hFFFF_FFF0;
    wait_idle();
    wr_valid = 1'b1;
    wr_data  = 32'hDEAD_BEEF;
    for (int c = 0; c < 3; c++) begin
      if (wr_ready !== 1'b0) bad = 1;
      @(negedge clk);
    end
    wr_valid = 1'b0;
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL stray_wr_ready: wr_ready=1 while idle, required 0");
    end
    write_burst(8'h40, base, 1);
    wr_valid = 1'b1;
    wr_data  = 32'hCAFE_F00D;
    repeat (2) @(negedge clk);
    wr_valid = 1'b0;
    read_burst(8'h40, 0);
  endtask

  task automatic test_reset_mid();
    int beat = 0;
    int n = 0;
    write_burst(8'h07, 32'h700, 0);
    issue_req(1'b0, 8'h07);
    while (n < 100) begin
      if (rd_valid === 1'b1) begin
        checks++;
        if (rd_data !== model[7][beat]) begin
          errors++;
          $display("FAIL mid_rd_data beat %0d: got %h, required %h", beat, rd_data, model[7][beat]);
        end
        if (beat == 7) begin
          rd_ready = 1'b0;
          rst_n    = 1'b0;
          break;
        end
        rd_ready = 1'b1;
        beat++;
      end else begin
        rd_ready = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    checks++;
    if (beat != 7) begin
      errors++;
      $display("FAIL mid_reach_beat7: reached beat %0d, required 7", beat);
    end
    rst_n    = 1'b0;
    rd_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (rd_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: rd_valid=%b busy=%b, required 0 1", rd_valid, busy);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    exp_q.delete();
    read_burst(8'h07, 0);
    read_burst(8'h22, 0);
  endtask

  task automatic test_back_to_back();
    int i = 0;
    int n = 0;
    int idle = 0;
    wait_idle();
    req_valid = 1'b1;
    req_write = 1'b1;
    req_block = 8'hFF;
    @(negedge clk);
    req_write = 1'b0;
    while (i < 16 && n < 100) begin
      wr_valid = 1'b1;
      wr_data  = 32'hA5A5_0000 + 32'(i);
      if (wr_ready === 1'b1) i++;
      @(negedge clk);
      n++;
    end
    wr_valid = 1'b0;
    for (int k = 0; k < 16; k++) model[8'hFF][k] = 32'hA5A5_0000 + 32'(k);
    checks++;
    if (i != 16 || wr_done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_write: beats=%0d wr_done=%b, required 16 1", i, wr_done);
    end
    acc_cyc = cyc;
    n = 0;
    while (busy !== 1'b1 && n < 20) begin
      idle++;
      @(negedge clk);
      n++;
    end
    req_valid = 1'b0;
    checks++;
    if (idle != 1) begin
      errors++;
      $display("FAIL b2b_idle_gap: %0d idle cycles, required 1", idle);
    end
    for (int k = 0; k < 16; k++) exp_q.push_back(model[8'hFF][k]);
    collect_read(0);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_no_extra: busy=%b after req_valid dropped, required 0", busy);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic_read();
    test_write_read();
    test_stall_read();
    test_gap_write();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
